// File: rtl/lif_spike_monitor.sv
// Windowed spike-rate and inter-spike-interval monitor for the LIF neuron output.
// One record {count, last ISI, overflow} per completed window, offered on a valid/ready port.
module lif_spike_monitor #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8,
  parameter int ISI_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             en,
  input  logic [WIN_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic [ISI_W-1:0] out_isi,
  output logic             out_overflow,
  output logic             dropped,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  state_t           state, state_n;
  logic             spike_prev;
  logic [WIN_W-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] scnt, scnt_n;
  logic             ovf, ovf_n;
  logic [ISI_W-1:0] isi_cnt, isi_cnt_n;
  logic [ISI_W-1:0] isi_last, isi_last_n;
  logic             seen, seen_n;
  logic             dropped_n;
  logic             valid_n;
  logic [CNT_W-1:0] count_n;
  logic [ISI_W-1:0] isi_n;
  logic             overflow_n;
  logic             spk_edge;

  assign spk_edge = spike_in & ~spike_prev;

  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    scnt_n     = scnt;
    ovf_n      = ovf;
    isi_cnt_n  = isi_cnt;
    isi_last_n = isi_last;
    seen_n     = seen;
    dropped_n  = dropped;
    valid_n    = out_valid;
    count_n    = out_count;
    isi_n      = out_isi;
    overflow_n = out_overflow;

    if (out_valid && out_ready) valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (en && window_len != '0) begin
          state_n    = RUN;
          wcnt_n     = window_len;
          scnt_n     = '0;
          ovf_n      = 1'b0;
          isi_cnt_n  = '0;
          isi_last_n = '0;
          seen_n     = 1'b0;
          dropped_n  = 1'b0;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          isi_cnt_n = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
          if (spk_edge) begin
            scnt_n = (scnt == CNT_MAX) ? CNT_MAX : scnt + CNT_W'(1);
            if (scnt == CNT_MAX) ovf_n = 1'b1;
            if (seen) isi_last_n = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
            isi_cnt_n = '0;
            seen_n    = 1'b1;
          end
          if (wcnt == WIN_W'(1)) begin
            // record includes this cycle's edge; a full, unconsumed register loses it
            if (!out_valid || out_ready) begin
              valid_n    = 1'b1;
              count_n    = scnt_n;
              isi_n      = isi_last_n;
              overflow_n = ovf_n;
            end else begin
              dropped_n = 1'b1;
            end
            if (window_len != '0) begin
              wcnt_n = window_len;
              scnt_n = '0;
              ovf_n  = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            wcnt_n = wcnt - WIN_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      spike_prev   <= 1'b0;
      wcnt         <= '0;
      scnt         <= '0;
      ovf          <= 1'b0;
      isi_cnt      <= '0;
      isi_last     <= '0;
      seen         <= 1'b0;
      dropped      <= 1'b0;
      out_valid    <= 1'b0;
      out_count    <= '0;
      out_isi      <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      spike_prev   <= spike_in;
      wcnt         <= wcnt_n;
      scnt         <= scnt_n;
      ovf          <= ovf_n;
      isi_cnt      <= isi_cnt_n;
      isi_last     <= isi_last_n;
      seen         <= seen_n;
      dropped      <= dropped_n;
      out_valid    <= valid_n;
      out_count    <= count_n;
      out_isi      <= isi_n;
      out_overflow <= overflow_n;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Bench for lif_spike_monitor: directed scenarios plus random traffic,
// checked every cycle against a window/edge-time reference model.
module tb_lif_spike_monitor;

  logic        clk = 1'b0;
  logic        rst, spike_in, en, out_ready;
  logic [15:0] window_len;
  logic        out_valid, out_overflow, dropped, busy;
  logic [7:0]  out_count;
  logic [11:0] out_isi;

  lif_spike_monitor dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .en(en), .window_len(window_len),
    .out_ready(out_ready), .out_valid(out_valid), .out_count(out_count),
    .out_isi(out_isi), .out_overflow(out_overflow), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: window bounds in absolute cycles, edge times since run start
  int t = 0;
  bit m_run, m_prev;
  int m_wstart, m_wlen, m_edges, m_last_e, m_prev_e;
  bit m_valid, m_ovf, m_drop;
  int m_cnt, m_isi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
  endtask

  task automatic step(input bit r, input bit s, input bit e, input int wl, input bit rd);
    bit edg, load, xfer;
    int rc, ri;
    bit ro;
    rst = r; spike_in = s; en = e; window_len = 16'(wl); out_ready = rd;
    load = 0; rc = 0; ri = 0; ro = 0;
    if (r) begin
      m_run = 0; m_prev = 0; m_valid = 0; m_cnt = 0; m_isi = 0; m_ovf = 0; m_drop = 0;
    end else begin
      edg = s && !m_prev;
      m_prev = s;
      xfer = m_valid && rd;
      if (!m_run) begin
        if (e && wl != 0) begin
          m_run = 1; m_wstart = t + 1; m_wlen = wl; m_edges = 0;
          m_last_e = -1; m_prev_e = -1; m_drop = 0;
        end
      end else if (!e) begin
        m_run = 0;
      end else begin
        if (edg) begin
          m_edges++; m_prev_e = m_last_e; m_last_e = t;
        end
        if (t == m_wstart + m_wlen - 1) begin
          rc = (m_edges > 255) ? 255 : m_edges;
          ro = (m_edges > 255);
          ri = (m_prev_e < 0) ? 0 : ((m_last_e - m_prev_e > 4095) ? 4095 : m_last_e - m_prev_e);
          if (!m_valid || rd) load = 1;
          else m_drop = 1;
          if (wl != 0) begin
            m_wstart = t + 1; m_wlen = wl; m_edges = 0;
          end else begin
            m_run = 0;
          end
        end
      end
      if (load) begin
        m_valid = 1; m_cnt = rc; m_isi = ri; m_ovf = ro;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("cycle", {8'd0, out_valid, busy, dropped, out_overflow, out_isi, out_count},
        {8'd0, m_valid, m_run, m_drop, m_ovf, 12'(m_isi), 8'(m_cnt)});
    t++;
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);

    // three single-cycle spikes, 3 cycles apart, in a 10-cycle window
    step(0, 0, 1, 10, 1);
    for (int j = 0; j < 10; j++) step(0, (j == 2 || j == 5 || j == 8), 1, 10, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", out_count, 3);
    chk("t1_isi", out_isi, 3);
    chk("t1_ovf", out_overflow, 0);
    step(0, 0, 0, 10, 1);
    chk("t1_drain", out_valid, 0);

    // held level counts once
    step(0, 0, 1, 20, 1);
    for (int j = 0; j < 20; j++) step(0, (j >= 3 && j <= 6), 1, 20, 1);
    chk("t2_count", out_count, 1);
    step(0, 0, 0, 20, 1);

    // count saturation, then clean window
    step(0, 0, 1, 600, 1);
    for (int j = 0; j < 600; j++) step(0, (j % 2 == 0), 1, 600, 1);
    chk("t3_count", out_count, 255);
    chk("t3_ovf", out_overflow, 1);
    for (int j = 0; j < 600; j++) step(0, 0, 1, 600, 1);
    chk("t3b_valid", out_valid, 1);
    chk("t3b_count", out_count, 0);
    chk("t3b_ovf", out_overflow, 0);
    step(0, 0, 0, 600, 1);

    // backpressure: hold, drop, release, transfer coinciding with load
    step(0, 0, 1, 5, 0);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 5; j++) begin
        int n;
        n = w * 5 + j + 1;
        step(0, (w == 0 && j == 1) || (w == 1 && (j == 1 || j == 3)) || (w == 3 && j == 2),
             1, 5, (n == 13 || n == 20));
        if (n == 5) chk("t4_drop_early", dropped, 0);
        if (n == 10) begin
          chk("t4_dropped", dropped, 1);
          chk("t4_hold_cnt", out_count, 1);
          chk("t4_hold_vld", out_valid, 1);
        end
        if (n == 13) chk("t4_xfer", out_valid, 0);
        if (n == 20) begin
          chk("t4_reload_vld", out_valid, 1);
          chk("t4_reload_cnt", out_count, 1);
          chk("t4_reload_drop", dropped, 1);
        end
      end
    end

    // abort at window cycle 3, then re-enable
    step(0, 0, 0, 10, 1);
    step(0, 0, 1, 10, 1);
    for (int j = 0; j < 3; j++) step(0, (j == 1), 1, 10, 1);
    step(0, 0, 0, 10, 1);
    chk("t5_busy", busy, 0);
    repeat (10) step(0, 0, 0, 10, 1);
    chk("t5_novalid", out_valid, 0);
    step(0, 0, 1, 10, 1);
    chk("t5_drop_clr", dropped, 0);
    for (int j = 0; j < 10; j++) step(0, (j == 4), 1, 10, 1);
    chk("t5_isi_one_edge", out_isi, 0);
    chk("t5_count", out_count, 1);
    for (int j = 0; j < 10; j++) step(0, (j == 3), 1, 10, 1);
    chk("t5_isi_cross", out_isi, 9);

    // reset while a record is pending
    step(0, 0, 0, 3, 1);
    step(0, 0, 1, 3, 0);
    for (int j = 0; j < 3; j++) step(0, (j == 1), 1, 3, 0);
    chk("t6_pre_vld", out_valid, 1);
    step(0, 0, 1, 3, 0);
    step(1, 0, 1, 3, 0);
    chk("t6_vld", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", out_count, 0);
    chk("t6_isi", out_isi, 0);
    chk("t6_drop", dropped, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12)),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lif_spike_monitor.md
# lif_spike_monitor

Downstream stage of the LIF neuron. It consumes the neuron's spike output and measures two things over a programmable window of clock cycles: the spike count and the most recent inter-spike interval (ISI). Each completed window produces one result record, offered on a valid/ready output port. The block sits between the neuron and the readout/IO logic, so the host can read firing rate without sampling the raw spike line every cycle.

## Interface
- `WIN_W`, default 16: width of the window length and the window counter.
- `CNT_W`, default 8: width of the spike count.
- `ISI_W`, default 12: width of the ISI measurement.

- `clk`  in  1  — clock; all logic is on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `spike_in`  in  1  — spike line from the neuron; may be held high for several cycles.
- `en`  in  1  — run enable.
- `window_len`  in  WIN_W  — window length in cycles; sampled at the start of each window.
- `out_ready`  in  1  — consumer ready.
- `out_valid`  out  1  — result record valid.
- `out_count`  out  CNT_W  — spike count for the window.
- `out_isi`  out  ISI_W  — last ISI captured by the end of the window.
- `out_overflow`  out  1  — the count saturated during the window.
- `dropped`  out  1  — sticky: a result was lost because the output register was full.
- `busy`  out  1  — high while the FSM is in RUN.

## Operation
- **Edge detection:** `spike_prev` register, reset 0. An edge at cycle t means `spike_in`=1 at t and 0 at t-1. Edges count only in RUN cycles. A level held for N cycles is one spike.
- **FSM states:** IDLE, RUN.
  - IDLE → RUN when `en`=1 and `window_len`≠0. On this transition:
    - load `wcnt`=`window_len`;
    - clear `scnt`, `ovf`, `isi_cnt`, `isi_last`, `seen`, `dropped`.
  - IDLE holds while `window_len`=0.
  - RUN → IDLE when `en`=0. The partial window is discarded, no result is produced, and the output register is untouched.
- **Window counter:** `wcnt` decrements every RUN cycle. The cycle with `wcnt`=1 is the last cycle of the window.
- **Spike count:** `scnt` increments on each edge and saturates at 2^CNT_W−1. An edge arriving while `scnt` is at max sets `ovf`.
- **ISI counter:**
  - `isi_cnt` increments every RUN cycle and saturates at 2^ISI_W−1.
  - On an edge: if `seen`=1, `isi_last` takes `isi_cnt`+1 (saturating); then `isi_cnt`=0 and `seen`=1.
  - Edges at cycles t and t+k give `isi_last`=k.
  - `isi_last` persists across windows and is cleared only at IDLE→RUN.
- **End of window** (last cycle, `en`=1):
  - The record {`scnt` including this cycle's edge, `isi_last` including this cycle's update, `ovf`} is written to the output register if it is empty or being consumed this cycle. Otherwise the record is discarded and `dropped` is set.
  - Next window starts back-to-back: `wcnt`=`window_len`, `scnt`=0, `ovf`=0. `isi_cnt` and `seen` carry over.
  - If `window_len`=0 at that point, go to IDLE.
- **Output port:**
  - Transfer happens when `out_valid` & `out_ready`.
  - `out_*` data is stable while `out_valid`=1 and `out_ready`=0.
  - Transfer and new-record load in the same cycle: the new record is loaded, `out_valid` stays 1, nothing is dropped.
- **Arithmetic:** unsigned throughout; all counters saturate and never wrap.

## Timing
- **Reset values:**
  - `out_valid`, `out_count`, `out_isi`, `out_overflow`, `dropped`, `busy` are all 0.
  - FSM is in IDLE; all internal counters and `spike_prev` are 0.
- **Window placement:** if RUN is entered at cycle s, the window covers cycles s..s+W−1 and `out_valid` rises at s+W (1-cycle latency from the last window cycle).
- **Window length:** a change to `window_len` takes effect at the next window start only.
- **`busy`:** registered state; high from cycle s.
- **Reset mid-operation:** `rst` wins over all other inputs. On the next cycle every output is at its reset value, including a pending `out_valid`.
- **`en` deasserted on the last window cycle:** the window counts as aborted and no record is produced.

## Test plan
- `window_len`=10, `out_ready`=1, one-cycle spikes at window cycles 2, 5, 8 → at s+10, `out_valid`=1 for one cycle with `out_count`=3, `out_isi`=3, `out_overflow`=0.
- `spike_in` held high 4 cycles, then low, inside a 20-cycle window → `out_count`=1.
- CNT_W=8, `window_len`=600, spike toggling every 2 cycles (300 edges) → `out_count`=255, `out_overflow`=1. Next window, with no spikes → `out_count`=0, `out_overflow`=0.
- `window_len`=5, `out_ready`=0 for 12 cycles → first record held stable and `dropped`=1 after the second window end. Raising `out_ready` then delivers the first record. Also: a transfer coinciding with a window end reloads the register with `dropped` unchanged.
- `en` dropped at window cycle 3 of 10 → no `out_valid`, `busy`=0. On re-enable → `dropped`=0, and `out_isi`=0 until two edges have been observed.
- `rst` asserted mid-window while `out_valid`=1 → all outputs 0 on the next cycle and FSM in IDLE.
